// File: rtl/cmd_fetch_if.sv
// Bus bundle for cmd_fetch: Avalon-MM burst-read master toward SDRAM plus the command stream toward the decoder.
// Stream handshake: a word moves on every clock edge where cmd_valid && cmd_ready; cmd_data is stable while cmd_valid waits for ready.
interface cmd_fetch_if #(
  parameter int ADDR_W = 29,
  parameter int BC_W   = 8,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] address;
  logic [BC_W-1:0]   burstcount;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;

  modport master (
    output address, burstcount, read,
    input  waitrequest, readdata, readdatavalid,
    output cmd_data, cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  address, burstcount, read,
    output waitrequest, readdata, readdatavalid,
    input  cmd_data, cmd_valid,
    output cmd_ready
  );
endinterface

// File: rtl/cmd_fetch.sv
// Rasterizer command prefetcher: burst-reads the command buffer from SDRAM into a FIFO
// and streams it in order to the decoder until the decoder signals end-of-list.
module cmd_fetch #(
  parameter logic [28:0] CMD_WORD_ADDRESS = 29'h0708_CA00,
  parameter int          BURST_LENGTH     = 8,
  parameter int          FIFO_DEPTH       = 32,
  parameter int          FIFO_BITS        = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  cmd_fetch_if.master          bus,
  output logic [1:0]           dbg_state,
  output logic [FIFO_BITS:0]   dbg_outstanding
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int                 CW        = FIFO_BITS + 3;
  localparam logic [CW-1:0]      BL_W      = CW'(BURST_LENGTH);
  localparam logic [CW-1:0]      DEPTH_W   = CW'(FIFO_DEPTH);
  localparam logic [FIFO_BITS:0] BL_OUT    = (FIFO_BITS+1)'(BURST_LENGTH);
  localparam logic [FIFO_BITS:0] ONE_OUT   = (FIFO_BITS+1)'(1);
  localparam logic [FIFO_BITS:0] FULL_CNT  = (FIFO_BITS+1)'(FIFO_DEPTH);
  localparam logic [28:0]        ADDR_STEP = 29'(BURST_LENGTH);

  state_t                 state_q, state_d;
  logic [28:0]            address_q, address_d;
  logic                   read_q, read_d;
  logic                   busy_q, busy_d;
  logic [FIFO_BITS:0]     out_q, out_d;
  logic [FIFO_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_BITS:0]     count_q, count_d;
  logic [63:0]            mem_q [FIFO_DEPTH];

  logic accept;
  logic beat;
  logic credit_ok;
  logic cmd_valid;
  logic push;
  logic pop;
  logic flush;

  assign accept    = read_q && !bus.waitrequest;
  // Late beats from a burst issued before reset are dropped while idle.
  assign beat      = bus.readdatavalid && (state_q != IDLE);
  // Reserve room for every beat already requested plus the new burst.
  assign credit_ok = ({2'b00, count_q} + {2'b00, out_q} + BL_W) <= DEPTH_W;
  assign cmd_valid = (state_q == FETCH) && (count_q != '0);
  assign pop       = cmd_valid && bus.cmd_ready;
  assign push      = beat && (state_q == FETCH) && !stop;

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    read_d    = read_q;
    busy_d    = busy_q;
    out_d     = out_q + (accept ? BL_OUT : '0) - (beat ? ONE_OUT : '0);
    flush     = 1'b0;
    if (accept) begin
      address_d = address_q + ADDR_STEP;
    end
    unique case (state_q)
      IDLE: begin
        read_d = 1'b0;
        if (start) begin
          state_d   = FETCH;
          address_d = CMD_WORD_ADDRESS;
          out_d     = '0;
          busy_d    = 1'b1;
          flush     = 1'b1;
        end
      end
      FETCH: begin
        if (stop) begin
          // A stalled request cannot be withdrawn; it finishes and is drained.
          state_d = DRAIN;
          flush   = 1'b1;
          read_d  = read_q && bus.waitrequest;
        end else if (read_q) begin
          read_d = bus.waitrequest;
        end else begin
          read_d = credit_ok;
        end
      end
      DRAIN: begin
        read_d = read_q && bus.waitrequest;
        if ((out_q == '0) && !read_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (FIFO_BITS+1)'(push) - (FIFO_BITS+1)'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      address_q <= '0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      out_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      out_q     <= out_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.readdata;
    end
  end

  assign bus.address     = address_q;
  assign bus.burstcount  = 8'(BURST_LENGTH);
  assign bus.read        = read_q;
  assign bus.cmd_data    = mem_q[rd_ptr_q];
  assign bus.cmd_valid   = cmd_valid;
  assign busy            = busy_q;
  assign dbg_state       = state_q;
  assign dbg_outstanding = out_q;

  a_hold_while_stalled: assert property (@(posedge clock) disable iff (reset)
    (read_q && bus.waitrequest) |=> (read_q && $stable(address_q)));
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    (push && !pop) |-> (count_q != FULL_CNT));
  a_no_unexpected_beat: assert property (@(posedge clock) disable iff (reset)
    beat |-> (out_q != '0));

endmodule

// File: tb/tb_cmd_fetch.sv
// Directed bench for cmd_fetch: Avalon memory model returning word indices, stream monitor and per-scenario checks.
module tb_cmd_fetch;
  localparam logic [28:0] CMD_ADDR = 29'h0708_CA00;
  localparam int          BL       = 8;
  localparam int          TMO      = 500;
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_FETCH  = 2'd1;
  localparam logic [1:0]  S_DRAIN  = 2'd2;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic       busy;
  logic [1:0] dbg_state;
  logic [5:0] dbg_outstanding;

  cmd_fetch_if bus ();

  cmd_fetch dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .busy            (busy),
    .bus             (bus),
    .dbg_state       (dbg_state),
    .dbg_outstanding (dbg_outstanding)
  );

  int tests_run;
  int tests_failed;
  int n_accepts;
  int ret_budget;
  bit cv_seen;

  logic [28:0] acc_addr_q [$];
  logic [63:0] pend_q [$];
  logic [63:0] got_q [$];
  logic [63:0] exp_q [$];

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.waitrequest = 1'b0;
    ret_budget = 1000000;
    step(2);
    pend_q.delete();
    reset = 1'b0;
    step(1);
  endtask

  task automatic clear_sb();
    acc_addr_q.delete();
    got_q.delete();
    exp_q.delete();
    n_accepts = 0;
    cv_seen = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic stop_and_drain(output int cycles);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    cycles = 0;
    while (busy && cycles < TMO) begin
      step(1);
      cycles++;
    end
  endtask

  // Memory model: record bursts just before the accepting edge and queue their beats.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.read && !bus.waitrequest) begin
          acc_addr_q.push_back(bus.address);
          n_accepts++;
          for (int k = 0; k < BL; k++) begin
            pend_q.push_back(64'(bus.address - CMD_ADDR + 29'(k)));
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) got_q.push_back(bus.cmd_data);
        if (bus.cmd_valid) cv_seen = 1'b1;
      end
    end
  end

  initial begin
    bus.readdatavalid = 1'b0;
    bus.readdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (ret_budget > 0 && pend_q.size() > 0) begin
        bus.readdatavalid = 1'b1;
        bus.readdata = pend_q.pop_front();
        ret_budget--;
      end else begin
        bus.readdatavalid = 1'b0;
        bus.readdata = '0;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    clear_sb();
    tests_run++; if (dbg_state !== S_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
    tests_run++; if (bus.read !== 1'b0) begin tests_failed++; $display("FAIL reset_read: got %0b expected 0", bus.read); end
    tests_run++; if (bus.address !== 29'h0) begin tests_failed++; $display("FAIL reset_address: got %0h expected 0", bus.address); end
    tests_run++; if (bus.burstcount !== 8'd8) begin tests_failed++; $display("FAIL reset_burstcount: got %0d expected 8", bus.burstcount); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tests_run++; if (bus.cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_valid: got %0b expected 0", bus.cmd_valid); end
    tests_run++; if (dbg_outstanding !== 6'd0) begin tests_failed++; $display("FAIL reset_outstanding: got %0d expected 0", dbg_outstanding); end
  endtask

  task automatic test_basic_fetch();
    int n;
    int cyc;
    logic [28:0] exp_a;
    do_reset();
    clear_sb();
    bus.cmd_ready = 1'b1;
    pulse_start();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %0b expected 1", busy); end
    n = 0;
    while (got_q.size() < 24 && n < TMO) begin step(1); n++; end
    tests_run++; if (n >= TMO) begin tests_failed++; $display("FAIL basic_timeout: got %0d words expected 24", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      exp_a = CMD_ADDR + 29'(i * BL);
      tests_run++; if (acc_addr_q[i] !== exp_a) begin tests_failed++; $display("FAIL basic_addr%0d: got %0h expected %0h", i, acc_addr_q[i], exp_a); end
    end
    for (int i = 0; i < 24; i++) exp_q.push_back(64'(i));
    for (int i = 0; i < 24; i++) begin
      tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL basic_data%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    stop_and_drain(cyc);
    tests_run++; if (cyc >= TMO) begin tests_failed++; $display("FAIL basic_drain: got busy=%0b expected 0", busy); end
    tests_run++; if (pend_q.size() != 0) begin tests_failed++; $display("FAIL basic_pending: got %0d beats left expected 0", pend_q.size()); end
    tests_run++; if (dbg_state !== S_IDLE) begin tests_failed++; $display("FAIL basic_idle: got %0d expected %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_back_pressure();
    int n;
    int cyc;
    do_reset();
    clear_sb();
    pulse_start();
    step(80);
    tests_run++; if (n_accepts != 4) begin tests_failed++; $display("FAIL bp_bursts_full: got %0d expected 4", n_accepts); end
    tests_run++; if (bus.read !== 1'b0) begin tests_failed++; $display("FAIL bp_read_full: got %0b expected 0", bus.read); end
    tests_run++; if (bus.cmd_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_full: got %0b expected 1", bus.cmd_valid); end
    tests_run++; if (dbg_outstanding !== 6'd0) begin tests_failed++; $display("FAIL bp_outstanding_full: got %0d expected 0", dbg_outstanding); end
    bus.cmd_ready = 1'b1;
    step(8);
    bus.cmd_ready = 1'b0;
    step(40);
    tests_run++; if (got_q.size() != 8) begin tests_failed++; $display("FAIL bp_pops: got %0d expected 8", got_q.size()); end
    tests_run++; if (n_accepts != 5) begin tests_failed++; $display("FAIL bp_bursts_after: got %0d expected 5", n_accepts); end
    bus.cmd_ready = 1'b1;
    n = 0;
    while (got_q.size() < 40 && n < TMO) begin step(1); n++; end
    tests_run++; if (n >= TMO) begin tests_failed++; $display("FAIL bp_timeout: got %0d words expected 40", got_q.size()); end
    for (int i = 0; i < 40; i++) exp_q.push_back(64'(i));
    for (int i = 0; i < 40; i++) begin
      tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL bp_data%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    stop_and_drain(cyc);
    tests_run++; if (cyc >= TMO) begin tests_failed++; $display("FAIL bp_drain: got busy=%0b expected 0", busy); end
  endtask

  task automatic test_wait_stall();
    int n;
    int cyc;
    do_reset();
    clear_sb();
    bus.cmd_ready = 1'b1;
    bus.waitrequest = 1'b1;
    pulse_start();
    n = 0;
    while (!bus.read && n < TMO) begin step(1); n++; end
    tests_run++; if (n >= TMO) begin tests_failed++; $display("FAIL stall_no_read: got read=%0b expected 1", bus.read); end
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (bus.read !== 1'b1) begin tests_failed++; $display("FAIL stall_read%0d: got %0b expected 1", i, bus.read); end
      tests_run++; if (bus.address !== CMD_ADDR) begin tests_failed++; $display("FAIL stall_addr%0d: got %0h expected %0h", i, bus.address, CMD_ADDR); end
      tests_run++; if (bus.burstcount !== 8'd8) begin tests_failed++; $display("FAIL stall_bc%0d: got %0d expected 8", i, bus.burstcount); end
      tests_run++; if (dbg_outstanding !== 6'd0) begin tests_failed++; $display("FAIL stall_out%0d: got %0d expected 0", i, dbg_outstanding); end
      step(1);
    end
    bus.waitrequest = 1'b0;
    step(1);
    tests_run++; if (dbg_outstanding !== 6'd8) begin tests_failed++; $display("FAIL stall_accept_out: got %0d expected 8", dbg_outstanding); end
    tests_run++; if (bus.address !== CMD_ADDR + 29'd8) begin tests_failed++; $display("FAIL stall_accept_addr: got %0h expected %0h", bus.address, CMD_ADDR + 29'd8); end
    tests_run++; if (n_accepts != 1) begin tests_failed++; $display("FAIL stall_accepts: got %0d expected 1", n_accepts); end
    stop_and_drain(cyc);
    tests_run++; if (cyc >= TMO) begin tests_failed++; $display("FAIL stall_drain: got busy=%0b expected 0", busy); end
  endtask

  task automatic test_stop_mid_burst();
    int n;
    int cyc;
    do_reset();
    clear_sb();
    ret_budget = 0;
    pulse_start();
    n = 0;
    while (!(n_accepts == 4 && !bus.read) && n < TMO) begin step(1); n++; end
    step(3);
    tests_run++; if (dbg_outstanding !== 6'd32) begin tests_failed++; $display("FAIL smid_out_issued: got %0d expected 32", dbg_outstanding); end
    ret_budget = 27;
    n = 0;
    while (!(pend_q.size() == 5 && !bus.readdatavalid) && n < TMO) begin step(1); n++; end
    tests_run++; if (dbg_outstanding !== 6'd5) begin tests_failed++; $display("FAIL smid_out_before: got %0d expected 5", dbg_outstanding); end
    tests_run++; if (bus.cmd_valid !== 1'b1) begin tests_failed++; $display("FAIL smid_valid_before: got %0b expected 1", bus.cmd_valid); end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    tests_run++; if (bus.cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL smid_valid_after: got %0b expected 0", bus.cmd_valid); end
    tests_run++; if (dbg_state !== S_DRAIN) begin tests_failed++; $display("FAIL smid_state: got %0d expected %0d", dbg_state, S_DRAIN); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL smid_busy: got %0b expected 1", busy); end
    ret_budget = 1000000;
    cyc = 0;
    while (busy && cyc < TMO) begin step(1); cyc++; end
    tests_run++; if (cyc != 7) begin tests_failed++; $display("FAIL smid_busy_fall: got %0d cycles expected 7", cyc); end
    tests_run++; if (pend_q.size() != 0) begin tests_failed++; $display("FAIL smid_pending: got %0d expected 0", pend_q.size()); end
    tests_run++; if (n_accepts != 4) begin tests_failed++; $display("FAIL smid_no_read: got %0d bursts expected 4", n_accepts); end
    tests_run++; if (bus.read !== 1'b0) begin tests_failed++; $display("FAIL smid_read_end: got %0b expected 0", bus.read); end
    tests_run++; if (bus.cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL smid_valid_end: got %0b expected 0", bus.cmd_valid); end
  endtask

  task automatic test_stop_pending();
    int n;
    int cyc;
    do_reset();
    clear_sb();
    bus.cmd_ready = 1'b1;
    bus.waitrequest = 1'b1;
    pulse_start();
    n = 0;
    while (!bus.read && n < TMO) begin step(1); n++; end
    stop  = 1'b1;
    start = 1'b1;
    step(1);
    stop  = 1'b0;
    start = 1'b0;
    tests_run++; if (dbg_state !== S_DRAIN) begin tests_failed++; $display("FAIL spend_state: got %0d expected %0d", dbg_state, S_DRAIN); end
    tests_run++; if (bus.read !== 1'b1) begin tests_failed++; $display("FAIL spend_read_held: got %0b expected 1", bus.read); end
    step(1);
    tests_run++; if (bus.address !== CMD_ADDR) begin tests_failed++; $display("FAIL spend_addr_held: got %0h expected %0h", bus.address, CMD_ADDR); end
    bus.waitrequest = 1'b0;
    step(1);
    tests_run++; if (dbg_outstanding !== 6'd8) begin tests_failed++; $display("FAIL spend_counted: got %0d expected 8", dbg_outstanding); end
    tests_run++; if (bus.read !== 1'b0) begin tests_failed++; $display("FAIL spend_read_drop: got %0b expected 0", bus.read); end
    cyc = 0;
    while (busy && cyc < TMO) begin step(1); cyc++; end
    tests_run++; if (cyc >= TMO) begin tests_failed++; $display("FAIL spend_drain: got busy=%0b expected 0", busy); end
    tests_run++; if (pend_q.size() != 0) begin tests_failed++; $display("FAIL spend_pending: got %0d expected 0", pend_q.size()); end
    tests_run++; if (n_accepts != 1) begin tests_failed++; $display("FAIL spend_accepts: got %0d expected 1", n_accepts); end
    tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL spend_no_data: got %0d words expected 0", got_q.size()); end
    tests_run++; if (dbg_state !== S_IDLE) begin tests_failed++; $display("FAIL spend_idle: got %0d expected %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_reset_mid();
    int n;
    int cyc;
    do_reset();
    clear_sb();
    ret_budget = 0;
    pulse_start();
    n = 0;
    while (n_accepts < 2 && n < TMO) begin step(1); n++; end
    bus.waitrequest = 1'b1;
    step(3);
    tests_run++; if (dbg_outstanding !== 6'd16) begin tests_failed++; $display("FAIL rmid_out: got %0d expected 16", dbg_outstanding); end
    reset = 1'b1;
    #1;
    tests_run++; if (bus.read !== 1'b0) begin tests_failed++; $display("FAIL rmid_read: got %0b expected 0", bus.read); end
    tests_run++; if (bus.address !== 29'h0) begin tests_failed++; $display("FAIL rmid_addr: got %0h expected 0", bus.address); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got %0b expected 0", busy); end
    tests_run++; if (dbg_outstanding !== 6'd0) begin tests_failed++; $display("FAIL rmid_out_reset: got %0d expected 0", dbg_outstanding); end
    tests_run++; if (dbg_state !== S_IDLE) begin tests_failed++; $display("FAIL rmid_state: got %0d expected %0d", dbg_state, S_IDLE); end
    step(1);
    reset = 1'b0;
    bus.waitrequest = 1'b0;
    cv_seen = 1'b0;
    ret_budget = 1000000;
    step(30);
    tests_run++; if (pend_q.size() != 0) begin tests_failed++; $display("FAIL rmid_late_beats: got %0d undelivered expected 0", pend_q.size()); end
    tests_run++; if (cv_seen !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid_seen: got %0b expected 0", cv_seen); end
    tests_run++; if (dbg_outstanding !== 6'd0) begin tests_failed++; $display("FAIL rmid_out_late: got %0d expected 0", dbg_outstanding); end
    tests_run++; if (dbg_state !== S_IDLE) begin tests_failed++; $display("FAIL rmid_idle_late: got %0d expected %0d", dbg_state, S_IDLE); end
    clear_sb();
    bus.cmd_ready = 1'b1;
    pulse_start();
    n = 0;
    while (got_q.size() < 8 && n < TMO) begin step(1); n++; end
    tests_run++; if (acc_addr_q[0] !== CMD_ADDR) begin tests_failed++; $display("FAIL rmid_restart_addr: got %0h expected %0h", acc_addr_q[0], CMD_ADDR); end
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(i));
    for (int i = 0; i < 8; i++) begin
      tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rmid_data%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    stop_and_drain(cyc);
    tests_run++; if (cyc >= TMO) begin tests_failed++; $display("FAIL rmid_drain: got busy=%0b expected 0", busy); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.waitrequest = 1'b0;
    tests_run    = 0;
    tests_failed = 0;
    n_accepts    = 0;
    ret_budget   = 1000000;
    cv_seen      = 1'b0;
    test_reset();
    test_basic_fetch();
    test_back_pressure();
    test_wait_stall();
    test_stop_mid_burst();
    test_stop_pending();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
